// File: rtl/systolic_config_pkg.sv
// Shared configuration for the systolic array front-end: default geometry,
// activation skewer FSM encoding and flush-length helpers.
// Ports: none (package). Imported by systolic_delay_line and systolic_act_skewer.
package systolic_config_pkg;

  // Array geometry shared by the feeders; skewer parameter defaults come from here.
  typedef struct packed {
    logic [15:0] data_width;
    logic [15:0] array_w;
  } systolic_cfg_t;

  localparam systolic_cfg_t SYSTOLIC_CFG_DEFAULT = '{data_width: 16'd8, array_w: 16'd4};

  typedef enum logic [1:0] {
    SKW_IDLE,
    SKW_STREAM,
    SKW_FLUSH
  } skewer_state_t;

  // Flush counter start value: the deepest lane still holds ARRAY_W-1 columns
  // beyond lane 0 after the last accept, so the drain takes ARRAY_W advances
  // (counter values ARRAY_W-1 down to 0).
  function automatic int skw_flush_load(input int array_w);
    return (array_w > 1) ? array_w - 1 : 0;
  endfunction

  // Width of the flush down-counter; at least one bit so ARRAY_W=1 still builds.
  function automatic int skw_flush_cnt_w(input int array_w);
    return (array_w > 1) ? $clog2(array_w) : 1;
  endfunction

endpackage

// File: rtl/systolic_delay_line.sv
// Fixed-depth shift register with a common advance enable.
// Latency: DEPTH cycles of en; holds every stage while en=0.
// Ports: clk, rst_n (sync, active-low, clears all stages), en, din[WIDTH], dout[WIDTH].
module systolic_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    for (int s = 0; s < DEPTH; s++) begin
      stage_d[s] = stage_q[s];
    end
    if (en) begin
      stage_d[0] = din;
      for (int s = 1; s < DEPTH; s++) begin
        stage_d[s] = stage_q[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < DEPTH; s++) begin
        stage_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < DEPTH; s++) begin
        stage_q[s] <= stage_d[s];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_act_skewer.sv
// Activation skewer for the systolic array west edge: lane i of each accepted
// column reaches the array i+1 cycles later, then zeros drain the skew and done
// pulses as the last element leaves the highest lane.
// Latency: lane i output i+1 advance cycles after accept; stall freezes everything.
// Ports: clk, rst_n (sync active-low); s_valid/s_ready/s_data/s_last input column
// stream; stall hold request; a_data/a_valid skewed rows; busy, done, beat_cnt status.
// Optional: define SYSTOLIC_SKEWER_PERF_EN to add stall_cnt/bubble_cnt outputs.
module systolic_act_skewer
  import systolic_config_pkg::*;
#(
  parameter int DATA_WIDTH = int'(SYSTOLIC_CFG_DEFAULT.data_width),
  parameter int ARRAY_W    = int'(SYSTOLIC_CFG_DEFAULT.array_w),
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [ARRAY_W*DATA_WIDTH-1:0] s_data,
  input  logic                          s_last,
  input  logic                          stall,
  output logic [ARRAY_W*DATA_WIDTH-1:0] a_data,
  output logic [ARRAY_W-1:0]            a_valid,
  output logic                          busy,
  output logic                          done,
  output logic [CNT_WIDTH-1:0]          beat_cnt
`ifdef SYSTOLIC_SKEWER_PERF_EN
  ,
  output logic [31:0]                   stall_cnt,
  output logic [31:0]                   bubble_cnt
`endif
);

  localparam int FC_W = skw_flush_cnt_w(ARRAY_W);
  localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(skw_flush_load(ARRAY_W));

  skewer_state_t        state_q, state_d;
  logic [FC_W-1:0]      flush_cnt_q, flush_cnt_d;
  logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;

  logic advance;
  logic accept;

  // Whole skewer moves together; a stall freezes lanes, FSM and counters.
  assign advance = !stall;

  // Ready depends only on reset, stall and state. The reset term keeps ready low
  // while reset is held, since state reads IDLE during that time.
  assign s_ready = rst_n && !stall && ((state_q == SKW_IDLE) || (state_q == SKW_STREAM));
  assign accept  = s_valid && s_ready;

  // ---------------------------------------------------------------------------
  // Tile FSM and beat counter
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    if (advance) begin
      unique case (state_q)
        SKW_IDLE: begin
          if (accept) begin
            beat_cnt_d  = CNT_WIDTH'(1);
            flush_cnt_d = FLUSH_LOAD;
            state_d     = s_last ? SKW_FLUSH : SKW_STREAM;
          end
        end
        SKW_STREAM: begin
          if (accept) begin
            // Saturate rather than wrap so huge tiles still read as "at least max".
            if (beat_cnt_q != '1) begin
              beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
            end
            if (s_last) begin
              flush_cnt_d = FLUSH_LOAD;
              state_d     = SKW_FLUSH;
            end
          end
        end
        SKW_FLUSH: begin
          if (flush_cnt_q == '0) begin
            state_d = SKW_IDLE;
          end else begin
            flush_cnt_d = flush_cnt_q - FC_W'(1);
          end
        end
        default: begin
          state_d = SKW_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SKW_IDLE;
      flush_cnt_q <= '0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign busy     = (state_q != SKW_IDLE);
  // The last column sits in the highest lane while the counter reads 0; done is
  // decoded from held state so it stays put across a stall like the data does.
  assign done     = (state_q == SKW_FLUSH) && (flush_cnt_q == '0);
  assign beat_cnt = beat_cnt_q;

  // ---------------------------------------------------------------------------
  // Skew lanes: {valid, data} per row, lane i is i+1 stages deep
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH:0] lane_din  [ARRAY_W];
  logic [DATA_WIDTH:0] lane_dout [ARRAY_W];

  for (genvar i = 0; i < ARRAY_W; i++) begin : g_lane
    // Non-accept advances (bubbles, flush) inject an explicit zero operand.
    assign lane_din[i] = accept ? {1'b1, s_data[i*DATA_WIDTH +: DATA_WIDTH]} : '0;

    systolic_delay_line #(
      .DEPTH (i + 1),
      .WIDTH (DATA_WIDTH + 1)
    ) u_dly (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (advance),
      .din   (lane_din[i]),
      .dout  (lane_dout[i])
    );

    assign a_valid[i]                          = lane_dout[i][DATA_WIDTH];
    assign a_data[i*DATA_WIDTH +: DATA_WIDTH]  = lane_dout[i][DATA_WIDTH-1:0];
  end

`ifdef SYSTOLIC_SKEWER_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters: cleared when a tile starts, saturating
  // ---------------------------------------------------------------------------
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if ((state_q == SKW_IDLE) && accept) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
    end else begin
      if (busy && stall && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if ((state_q == SKW_STREAM) && !stall && !s_valid && (bubble_cnt_q != '1)) begin
        bubble_cnt_d = bubble_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_systolic_act_skewer.sv
// Self-checking bench for systolic_act_skewer (ARRAY_W=4, DATA_WIDTH=8, CNT_WIDTH=4).
// Directed table, hand-written corner sequences and random traffic, all checked
// against a column-history reference model.
module tb_systolic_act_skewer;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int CW = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid;
  logic              s_ready;
  logic [AW*DW-1:0]  s_data;
  logic              s_last;
  logic              stall;
  logic [AW*DW-1:0]  a_data;
  logic [AW-1:0]     a_valid;
  logic              busy;
  logic              done;
  logic [CW-1:0]     beat_cnt;
`ifdef SYSTOLIC_SKEWER_PERF_EN
  logic [31:0]       stall_cnt;
  logic [31:0]       bubble_cnt;
`endif

  always #5 clk = ~clk;

  systolic_act_skewer #(
    .DATA_WIDTH (DW),
    .ARRAY_W    (AW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .stall    (stall),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .busy     (busy),
    .done     (done),
    .beat_cnt (beat_cnt)
`ifdef SYSTOLIC_SKEWER_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. m_hv/m_hd[k] is the column pushed k advances ago (zero
  // for a non-accepting advance). Row k of the array shows column k's lane k.
  // Mode: 0 idle, 1 streaming a tile, 2 draining after the last column.
  // ---------------------------------------------------------------------------
  logic             m_hv [AW];
  logic [AW*DW-1:0] m_hd [AW];
  int               m_mode;
  int               m_since;   // advances since the tile's last column was accepted
  int               m_beats;
  int               m_stall_cnt;
  int               m_bubble_cnt;
  logic             rdy_seen;

  task automatic m_reset();
    for (int k = 0; k < AW; k++) begin
      m_hv[k] = 1'b0;
      m_hd[k] = '0;
    end
    m_mode       = 0;
    m_since      = 0;
    m_beats      = 0;
    m_stall_cnt  = 0;
    m_bubble_cnt = 0;
  endtask

  // One clock: drive, check ready mid-cycle, clock, update model, check outputs.
  task automatic step(input logic r, input logic st, input logic v, input logic l,
                      input logic [AW*DW-1:0] d);
    logic             acc;
    logic             exp_rdy;
    logic [AW-1:0]    e_av;
    logic [AW*DW-1:0] e_ad;
    rst_n   = r;
    stall   = st;
    s_valid = v;
    s_last  = l;
    s_data  = d;
    #3;
    exp_rdy  = r && !st && (m_mode != 2);
    rdy_seen = s_ready;
    chk("s_ready", 64'(s_ready), 64'(exp_rdy));
    acc = v && exp_rdy;
    @(posedge clk);
    #1;
    if (!r) begin
      m_reset();
    end else begin
      if (st && m_mode != 0) m_stall_cnt++;
      if (!st && m_mode == 1 && !v) m_bubble_cnt++;
      if (!st) begin
        for (int k = AW - 1; k > 0; k--) begin
          m_hv[k] = m_hv[k-1];
          m_hd[k] = m_hd[k-1];
        end
        m_hv[0] = acc;
        m_hd[0] = acc ? d : '0;
        if (m_mode == 2) begin
          if (m_since == AW - 1) m_mode = 0;
          else m_since++;
        end
        if (acc) begin
          if (m_mode == 0) begin
            m_beats      = 1;
            m_stall_cnt  = 0;
            m_bubble_cnt = 0;
          end else if (m_beats < (1 << CW) - 1) begin
            m_beats++;
          end
          m_mode  = l ? 2 : 1;
          m_since = 0;
        end
      end
    end
    for (int k = 0; k < AW; k++) begin
      e_av[k]          = m_hv[k];
      e_ad[k*DW +: DW] = m_hd[k][k*DW +: DW];
    end
    chk("a_valid", 64'(a_valid), 64'(e_av));
    chk("a_data", 64'(a_data), 64'(e_ad));
    chk("busy", 64'(busy), 64'(m_mode != 0));
    // The last column is in the highest lane AW-1 advances after its accept.
    chk("done", 64'(done), 64'((m_mode == 2) && (m_since == AW - 1)));
    chk("beat_cnt", 64'(beat_cnt), 64'(m_beats));
`ifdef SYSTOLIC_SKEWER_PERF_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall_cnt));
    chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bubble_cnt));
`endif
  endtask

  task automatic idle_steps(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Directed table: inputs for one cycle and hand-derived expectations.
  typedef struct {
    logic        stall;
    logic        vld;
    logic        last;
    logic [31:0] data;
    logic        rdy;
    logic [3:0]  av;
    logic [7:0]  l0;
    logic [7:0]  l3;
    logic        done;
    logic        busy;
    logic [3:0]  beat;
  } vec_t;

  vec_t tbl [8];

  initial begin
    // Three-column tile; the column offered during the drain must be ignored.
    tbl[0] = '{1'b0, 1'b1, 1'b0, 32'h40302010, 1'b1, 4'b0001, 8'h10, 8'h00, 1'b0, 1'b1, 4'd1};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 32'h41312111, 1'b1, 4'b0011, 8'h11, 8'h00, 1'b0, 1'b1, 4'd2};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 32'h42322212, 1'b1, 4'b0111, 8'h12, 8'h00, 1'b0, 1'b1, 4'd3};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 4'b1110, 8'h00, 8'h40, 1'b0, 1'b1, 4'd3};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 4'b1100, 8'h00, 8'h41, 1'b0, 1'b1, 4'd3};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 4'b1000, 8'h00, 8'h42, 1'b1, 1'b1, 4'd3};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 4'b0000, 8'h00, 8'h00, 1'b0, 1'b0, 4'd3};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 4'b0000, 8'h00, 8'h00, 1'b0, 1'b0, 4'd3};

    m_reset();
    rst_n = 1'b0; stall = 1'b0; s_valid = 1'b1; s_last = 1'b0; s_data = 32'h0;
    @(posedge clk);
    #1;

    // 1. Reset held with s_valid high: nothing accepted, everything zero.
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 32'hA5A5A5A5);

    // 2. Directed three-column tile.
    for (int k = 0; k < 8; k++) begin
      step(1'b1, tbl[k].stall, tbl[k].vld, tbl[k].last, tbl[k].data);
      chk("tbl_rdy", 64'(rdy_seen), 64'(tbl[k].rdy));
      chk("tbl_av", 64'(a_valid), 64'(tbl[k].av));
      chk("tbl_l0", 64'(a_data[7:0]), 64'(tbl[k].l0));
      chk("tbl_l3", 64'(a_data[31:24]), 64'(tbl[k].l3));
      chk("tbl_done", 64'(done), 64'(tbl[k].done));
      chk("tbl_busy", 64'(busy), 64'(tbl[k].busy));
      chk("tbl_beat", 64'(beat_cnt), 64'(tbl[k].beat));
    end

    // 3. Bubble between columns 1 and 2: done one cycle later than above.
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h40302010);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h41312111);
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h42322212);
    idle_steps(2);
    chk("bubble_done_early", 64'(done), 64'(0));
    idle_steps(1);
    chk("bubble_done", 64'(done), 64'(1));
    chk("bubble_l3", 64'(a_data[31:24]), 64'(8'h42));
    idle_steps(2);

    // 4. Two stall cycles mid-stream freeze outputs.
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h40302010);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h41312111);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h42322212);
    chk("stall_rdy", 64'(rdy_seen), 64'(0));
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h42322212);
    chk("stall_hold_av", 64'(a_valid), 64'(4'b0011));
    chk("stall_hold_l1", 64'(a_data[15:8]), 64'(8'h20));
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h42322212);
    idle_steps(3);
    chk("stall_done", 64'(done), 64'(1));
`ifdef SYSTOLIC_SKEWER_PERF_EN
    chk("perf_stall_cnt", 64'(stall_cnt), 64'(2));
`endif
    idle_steps(2);

    // 5. Single-beat tile goes straight to the drain.
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h77665544);
    chk("single_busy", 64'(busy), 64'(1));
    chk("single_beat", 64'(beat_cnt), 64'(1));
    idle_steps(3);
    chk("single_done", 64'(done), 64'(1));
    chk("single_l3", 64'(a_data[31:24]), 64'(8'h77));
    idle_steps(1);
    chk("single_idle", 64'(busy), 64'(0));

    // 6. Reset in the middle of the drain: everything cleared, no done.
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h13121110);
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h23222120);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst_av", 64'(a_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("rst_no_done", 64'(done), 64'(0));
    end

    // Beat counter saturation: 20 columns into a 4-bit counter.
    for (int k = 0; k < 20; k++) step(1'b1, 1'b0, 1'b1, (k == 19), $urandom);
    chk("sat_beat", 64'(beat_cnt), 64'(15));
    idle_steps(5);

    // Random traffic with stalls, bubbles, short tiles and occasional reset.
    for (int k = 0; k < 800; k++) begin
      step(($urandom_range(99) != 0), ($urandom_range(4) == 0),
           ($urandom_range(9) < 7), ($urandom_range(9) == 0), $urandom);
    end
    idle_steps(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
